// File: rtl/multiplier.sv
// Single-cycle IEEE-754 binary32 multiplier: registered product with round-to-nearest-even,
// flush-to-zero on subnormal inputs/results, and a flag for special (Inf/NaN/overflow) results.
module multiplier (
  input  logic        control,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out,
  output logic        exception
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [31:0] out_d, out_q;
  logic        exception_d, exception_q;

  logic        sign;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0] product;
  logic        norm;
  logic [22:0] frac_pre;
  logic        guard, sticky, round_up;
  logic [24:0] mant_r;
  logic signed [10:0] exp_final;
  logic [22:0] frac_final;

  always_comb begin
    sign   = A[31] ^ B[31];
    exp_a  = A[30:23];
    exp_b  = B[30:23];
    frac_a = A[22:0];
    frac_b = B[22:0];

    a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);
    a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    // Subnormal inputs are flushed, so any zero exponent counts as zero.
    a_zero = (exp_a == 8'h00);
    b_zero = (exp_b == 8'h00);

    product = {24'd0, 1'b1, frac_a} * {24'd0, 1'b1, frac_b};
    norm    = product[47];

    if (norm) begin
      frac_pre = product[46:24];
      guard    = product[23];
      sticky   = |product[22:0];
    end else begin
      frac_pre = product[45:23];
      guard    = product[22];
      sticky   = |product[21:0];
    end

    round_up   = guard & (sticky | frac_pre[0]);
    mant_r     = {2'b01, frac_pre} + {24'd0, round_up};
    frac_final = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    exp_final  = 11'(exp_a) + 11'(exp_b) - 11'sd127 + 11'(norm) + 11'(mant_r[24]);

    out_d       = 32'd0;
    exception_d = 1'b0;
    if (a_nan || b_nan) begin
      out_d       = QNAN;
      exception_d = 1'b1;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      out_d       = QNAN;
      exception_d = 1'b1;
    end else if (a_inf || b_inf) begin
      out_d       = {sign, 8'hFF, 23'd0};
      exception_d = 1'b1;
    end else if (a_zero || b_zero) begin
      out_d       = {sign, 31'd0};
    end else if (exp_final >= 11'sd255) begin
      out_d       = {sign, 8'hFF, 23'd0};
      exception_d = 1'b1;
    end else if (exp_final <= 11'sd0) begin
      out_d       = {sign, 31'd0};
    end else begin
      out_d       = {sign, exp_final[7:0], frac_final};
    end
  end

  always_ff @(posedge control or posedge reset) begin
    if (reset) begin
      out_q       <= 32'd0;
      exception_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      exception_q <= exception_d;
    end
  end

  assign out       = out_q;
  assign exception = exception_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed vectors, reset behaviour, and randomized
// operands compared against an integer-arithmetic binary32 reference model.
module tb_multiplier;

  logic        control;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] out;
  logic        exception;

  int checkCount = 0;
  int errorCount = 0;

  multiplier dut (
    .control  (control),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .out      (out),
    .exception(exception)
  );

  initial control = 1'b0;
  always #5 control = ~control;

  task automatic checkOutput(input string tag, input logic [32:0] observed, input logic [32:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got exc=%0b out=%08h, expected exc=%0b out=%08h",
               tag, observed[32], observed[31:0], expected[32], expected[31:0]);
    end
  endtask

  // Present operands after a falling edge, then look at the outputs just after the next rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge control);
    A = a;
    B = b;
    @(posedge control);
    #1;
  endtask

  // Reference: exact integer product, normalize by locating the top bit, round half to even.
  function automatic logic [32:0] refModel(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, k, sh, e;
    logic   s, an, bn, ai, bi, az, bz;
    longint p, q, rem, half;
    logic [63:0] qbits;
    logic [31:0] ebits;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn) return {1'b1, 32'h7FC0_0000};
    if ((ai && bz) || (bi && az)) return {1'b1, 32'h7FC0_0000};
    if (ai || bi) return {1'b1, s, 8'hFF, 23'd0};
    if (az || bz) return {1'b0, s, 31'd0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    k = 47;
    while (((p >> k) & 64'd1) == 0) k--;
    sh   = k - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    e = ea + eb - 127 + (k - 46);
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    qbits = 64'(q);
    ebits = 32'(e);
    return {1'b0, s, ebits[7:0], qbits[22:0]};
  endfunction

  // Biased towards normals but with a steady share of zeros, Infs, NaNs, subnormals and extreme exponents.
  function automatic logic [31:0] randOperand();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    int          kind;
    s    = 1'($urandom);
    f    = 23'($urandom);
    kind = int'($urandom_range(0, 15));
    case (kind)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; f = 23'd0; end
      2:       begin e = 8'hFF; if (f == 0) f = 23'd1; end
      3:       begin e = 8'h00; if (f == 0) f = 23'd5; end
      4:       e = 8'($urandom_range(230, 254));
      5:       e = 8'($urandom_range(1, 25));
      default: e = 8'($urandom_range(1, 254));
    endcase
    if (kind == 0) f = 23'd0;
    return {s, e, f};
  endfunction

  initial begin
    logic [31:0] ra, rb;
    A     = 32'd0;
    B     = 32'd0;
    reset = 1'b1;
    #3;
    checkOutput("reset_state", {exception, out}, 33'd0);

    // Inputs sampled while reset is held must not reach the outputs.
    @(negedge control);
    A = 32'h4000_0000;
    B = 32'h4040_0000;
    @(posedge control);
    #1;
    checkOutput("reset_hold", {exception, out}, 33'd0);
    @(negedge control);
    reset = 1'b0;

    applyStimulus(32'h3E80_0000, 32'h4000_0000);
    checkOutput("quarter_x_two", {exception, out}, {1'b0, 32'h3F00_0000});
    applyStimulus(32'h3FA0_0000, 32'h4080_0000);
    checkOutput("1p25_x_4", {exception, out}, {1'b0, 32'h40A0_0000});
    applyStimulus(32'h4080_0000, 32'h3FA0_0000);
    checkOutput("4_x_1p25", {exception, out}, {1'b0, 32'h40A0_0000});
    applyStimulus(32'h4000_0000, 32'h4040_0000);
    checkOutput("2_x_3", {exception, out}, {1'b0, 32'h40C0_0000});
    applyStimulus(32'hC000_0000, 32'h4040_0000);
    checkOutput("neg2_x_3", {exception, out}, {1'b0, 32'hC0C0_0000});
    applyStimulus(32'h7F80_0000, 32'h3F9E_46F1);
    checkOutput("inf_x_finite", {exception, out}, {1'b1, 32'h7F80_0000});
    applyStimulus(32'h7F80_0000, 32'h0000_0000);
    checkOutput("inf_x_zero", {exception, out}, {1'b1, 32'h7FC0_0000});
    applyStimulus(32'h7F00_0000, 32'h7F00_0000);
    checkOutput("overflow", {exception, out}, {1'b1, 32'h7F80_0000});
    applyStimulus(32'h0080_0000, 32'h0080_0000);
    checkOutput("underflow", {exception, out}, {1'b0, 32'h0000_0000});
    applyStimulus(32'h3FC0_0000, 32'h3F80_0001);
    checkOutput("tie_round_up", {exception, out}, {1'b0, 32'h3FC0_0002});
    applyStimulus(32'h3FC0_0000, 32'h3F80_0003);
    checkOutput("tie_stay_even", {exception, out}, {1'b0, 32'h3FC0_0004});
    applyStimulus(32'h8000_0000, 32'h7F80_0000);
    checkOutput("negzero_x_inf", {exception, out}, {1'b1, 32'h7FC0_0000});
    applyStimulus(32'hFF80_0000, 32'h7F80_0000);
    checkOutput("neginf_x_inf", {exception, out}, {1'b1, 32'hFF80_0000});
    applyStimulus(32'hFFC0_0001, 32'h0000_0000);
    checkOutput("nan_x_zero", {exception, out}, {1'b1, 32'h7FC0_0000});
    applyStimulus(32'h8000_0000, 32'h3F80_0000);
    checkOutput("negzero_x_one", {exception, out}, {1'b0, 32'h8000_0000});
    applyStimulus(32'h0000_0123, 32'hC000_0000);
    checkOutput("subnormal_in", {exception, out}, {1'b0, 32'h8000_0000});
    applyStimulus(32'h3FFF_FFFF, 32'h3FFF_FFFF);
    checkOutput("round_carry", {exception, out}, refModel(32'h3FFF_FFFF, 32'h3FFF_FFFF));

    // Asynchronous reset mid-stream: outputs clear without an edge and no stale value survives release.
    applyStimulus(32'h4040_0000, 32'h4040_0000);
    checkOutput("pre_reset", {exception, out}, {1'b0, 32'h4110_0000});
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", {exception, out}, 33'd0);
    @(negedge control);
    A = 32'h7F80_0000;
    B = 32'h4000_0000;
    @(posedge control);
    #1;
    checkOutput("reset_ignores_in", {exception, out}, 33'd0);
    @(negedge control);
    reset = 1'b0;
    A = 32'h3F00_0000;
    B = 32'h4100_0000;
    @(posedge control);
    #1;
    checkOutput("first_after_reset", {exception, out}, {1'b0, 32'h4080_0000});

    for (int i = 0; i < 600; i++) begin
      ra = randOperand();
      rb = randOperand();
      applyStimulus(ra, rb);
      checkOutput("random", {exception, out}, refModel(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL: control  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: A  input  32  IEEE-754 binary32 operand.
REQ-004 SHALL: B  input  32  IEEE-754 binary32 operand.
REQ-005 SHALL: out  output  32  registered binary32 product A*B.
REQ-006 SHALL: exception  output  1  registered flag; high when the product is special (Inf/NaN input or overflow).
REQ-007 SHALL: one clock (control); reset asynchronous and active-high; no parameters.

Function
REQ-008 SHALL: each rising edge of control with reset low samples A and B; out and exception register the result of that pair; latency exactly 1 cycle, new result every cycle, no handshake.
REQ-009 SHALL: result sign = A[31] XOR B[31] in all cases, including zero and Inf; NaN output is positive.
REQ-010 SHALL: normal operands use the implicit leading 1; full 24x24 -> 48-bit mantissa product.
REQ-011 SHALL: if product bit 47 is set, shift right 1 and add 1 to the exponent; biased exponent = eA + eB - 127 (+1 if normalized), computed at least 10 bits signed.
REQ-012 SHALL: round to nearest, ties to even, using guard, round and sticky bits; on rounding carry-out, renormalize and increment the exponent.
REQ-013 SHALL: subnormal operands (exp=0, frac!=0) are treated as zero; inputs are flushed to zero.
REQ-014 SHALL: either operand zero with the other finite gives signed zero, exception=0.
REQ-015 SHALL: final biased exponent >= 255 gives signed Inf (exp=0xFF, frac=0), exception=1.
REQ-016 SHALL: final biased exponent <= 0 gives signed zero (flush underflow), exception=0.
REQ-017 SHALL: either operand NaN (exp=0xFF, frac!=0) gives out=0x7FC00000, exception=1.
REQ-018 SHALL: Inf times zero gives out=0x7FC00000, exception=1.
REQ-019 SHALL: Inf times nonzero finite or Inf gives signed Inf, exception=1.
REQ-020 SHALL: special-case priority is NaN > Inf*0 > Inf > zero > overflow/underflow > normal.
REQ-021 SHALL: inputs that are X/undefined before the first valid edge impose no requirement beyond the reset values.

Reset
REQ-022 SHALL: reset high forces out=0x00000000 and exception=0 immediately, independent of control.
REQ-023 SHALL: while reset is high, outputs hold the reset values and input sampling is ignored.
REQ-024 SHALL: after reset deasserts, the first rising edge of control produces a valid result for the A and B present at that edge.
REQ-025 SHALL: reset asserted mid-stream discards the in-flight result; no stale value appears after release.

Verification
REQ-026 SHALL: A=0x3E800000 (0.25), B=0x40000000 (2.0) -> out=0x3F000000 after 1 edge, exception=0.
REQ-027 SHALL: A=0x3FA00000 (1.25), B=0x40800000 (4.0) and the swapped operand order -> out=0x40A00000 both times, exception=0.
REQ-028 SHALL: A=0x40000000, B=0x40400000 -> out=0x40C00000; A=0xC0000000, B=0x40400000 -> out=0xC0C00000.
REQ-029 SHALL: A=0x7F800000 (+Inf), B=0x3F9E46F1 -> out=0x7F800000, exception=1; A=0x7F800000, B=0x00000000 -> out=0x7FC00000, exception=1.
REQ-030 SHALL: A=0x7F000000, B=0x7F000000 -> out=0x7F800000, exception=1; A=0x00800000, B=0x00800000 -> out=0x00000000, exception=0.
REQ-031 SHALL: assert reset between edges while out is nonzero -> out=0 and exception=0 without a clock edge; random normal operands match a golden binary32 RNE model bit-exactly, excluding subnormal results, which flush to zero.
